// File: rtl/andor_sweep_checker.sv
// andor_sweep_checker: drives all 16 input vectors onto an AND-OR gate
// (Y = (A&B)|(C&D)), holds each vector for SETTLE_CYCLES cycles, then samples
// y for one cycle and compares it against the expected function.
// Optional macro FAIL_MASK_EN adds a per-vector mismatch bitmap output.
module andor_sweep_checker #(
    parameter int unsigned SETTLE_CYCLES = 2,  // 1..15
    parameter int unsigned N_PASSES      = 1   // 1..15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic        a,
    output logic        b,
    output logic        c,
    output logic        d,
    input  logic        y,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [7:0]  err_count,
    output logic [3:0]  first_err_vec,
`ifdef FAIL_MASK_EN
    output logic        first_err_valid,
    output logic [15:0] fail_mask
`else
    output logic        first_err_valid
`endif
);

    typedef enum logic [1:0] {StIdle, StSettle, StSample, StDone} state_e;

    localparam logic [3:0] LastSettle = 4'(SETTLE_CYCLES - 1);
    localparam logic [3:0] LastPass   = 4'(N_PASSES - 1);

    state_e      r_state;
    state_e      w_state_next;
    logic [3:0]  r_vec;
    logic [3:0]  r_settle_cnt;
    logic [3:0]  r_pass_cnt;
    logic [7:0]  r_err_count;
    logic [3:0]  r_first_vec;
    logic        r_first_valid;
    logic        r_pass;
`ifdef FAIL_MASK_EN
    logic [15:0] r_fail_mask;
`endif

    logic        w_expected;
    logic        w_mismatch;
    logic        w_last;
    logic        w_driving;
    logic [7:0]  w_err_next;

    assign w_expected = (r_vec[3] & r_vec[2]) | (r_vec[1] & r_vec[0]);
    assign w_mismatch = (r_state == StSample) && (y != w_expected);
    // Final sample of the final pass ends the sweep.
    assign w_last     = (r_vec == 4'hF) && (r_pass_cnt == LastPass);
    assign w_err_next = (w_mismatch && (r_err_count != 8'hFF)) ? r_err_count + 8'd1
                                                                : r_err_count;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode.
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle:   if (start) w_state_next = StSettle;
            StSettle: if (r_settle_cnt == LastSettle) w_state_next = StSample;
            StSample: w_state_next = w_last ? StDone : StSettle;
            StDone:   w_state_next = StIdle;
            default:  w_state_next = StIdle;
        endcase
    end

    // Sweep counters and result capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vec         <= 4'd0;
            r_settle_cnt  <= 4'd0;
            r_pass_cnt    <= 4'd0;
            r_err_count   <= 8'd0;
            r_first_vec   <= 4'd0;
            r_first_valid <= 1'b0;
            r_pass        <= 1'b0;
`ifdef FAIL_MASK_EN
            r_fail_mask   <= 16'd0;
`endif
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (start) begin
                        r_vec         <= 4'd0;
                        r_settle_cnt  <= 4'd0;
                        r_pass_cnt    <= 4'd0;
                        r_err_count   <= 8'd0;
                        r_first_vec   <= 4'd0;
                        r_first_valid <= 1'b0;
                        r_pass        <= 1'b0;
`ifdef FAIL_MASK_EN
                        r_fail_mask   <= 16'd0;
`endif
                    end
                end
                StSettle: begin
                    r_settle_cnt <= r_settle_cnt + 4'd1;
                end
                StSample: begin
                    r_err_count <= w_err_next;
                    if (w_mismatch && !r_first_valid) begin
                        r_first_vec   <= r_vec;
                        r_first_valid <= 1'b1;
                    end
`ifdef FAIL_MASK_EN
                    if (w_mismatch) r_fail_mask[r_vec] <= 1'b1;
`endif
                    r_vec        <= r_vec + 4'd1;
                    r_settle_cnt <= 4'd0;
                    if (w_last) begin
                        // Uses the count including this cycle's compare.
                        r_pass <= (w_err_next == 8'd0);
                    end else if (r_vec == 4'hF) begin
                        r_pass_cnt <= r_pass_cnt + 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign w_driving       = (r_state == StSettle) || (r_state == StSample);
    assign {a, b, c, d}    = w_driving ? r_vec : 4'd0;
    assign busy            = w_driving;
    assign done            = (r_state == StDone);
    assign pass            = r_pass;
    assign err_count       = r_err_count;
    assign first_err_vec   = r_first_vec;
    assign first_err_valid = r_first_valid;
`ifdef FAIL_MASK_EN
    assign fail_mask       = r_fail_mask;
`endif

endmodule
